// File: rtl/watch_pkg.sv
// Shared limits, prescaler width and run-state encoding for the digital watch.
package watch_pkg;

    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;
    localparam int unsigned HR_MAX  = 23;

    // Prescaler holds 0..CLK_DIV-1 with CLK_DIV up to 2^20.
    localparam int unsigned PRESC_W = 20;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_e;

endpackage

// File: rtl/bin2bcd_2digit.sv
// Converts a binary value 0..59 into tens/ones BCD digits.
module bin2bcd_2digit (
    input  logic [5:0] bin_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    logic [5:0] sub;

    // Compare ladder keeps the tens digit within 0..5 for any legal input.
    always_comb begin
        tens_o = 4'd0;
        sub    = 6'd0;
        if (bin_i >= 6'd50) begin
            tens_o = 4'd5;
            sub    = 6'd50;
        end else if (bin_i >= 6'd40) begin
            tens_o = 4'd4;
            sub    = 6'd40;
        end else if (bin_i >= 6'd30) begin
            tens_o = 4'd3;
            sub    = 6'd30;
        end else if (bin_i >= 6'd20) begin
            tens_o = 4'd2;
            sub    = 6'd20;
        end else if (bin_i >= 6'd10) begin
            tens_o = 4'd1;
            sub    = 6'd10;
        end
        ones_o = 4'(bin_i - sub);
    end

endmodule

// File: rtl/param_watch.sv
// Run/stop digital watch: binary time core, prescaled one-second tick,
// load with range check, and 12/24-hour BCD display.
//
// state   | meaning
// STOPPED | prescaler and time frozen; loads and mode changes still accepted
// RUNNING | prescaler counts; time advances on each tick
module param_watch
    import watch_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 1,
    parameter bit          RESET_24H = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_resume,
    input  logic       stop,
    input  logic       set_time,
    input  logic [4:0] set_hr,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    input  logic       mode_toggle,
    output logic [3:0] hr1,
    output logic [3:0] hr0,
    output logic [3:0] min1,
    output logic [3:0] min0,
    output logic [3:0] sec1,
    output logic [3:0] sec0,
    output logic       pm,
    output logic       mode_24h,
    output logic       daypass,
    output logic       set_err,
    output logic       running
);

    localparam logic [PRESC_W-1:0] DIV_M1 = PRESC_W'(CLK_DIV - 1);

    state_e             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [4:0]         hr_q, hr_d;
    logic [5:0]         min_q, min_d;
    logic [5:0]         sec_q, sec_d;
    logic               mode_q, mode_d;
    logic               daypass_q, daypass_d;
    logic               set_err_q, set_err_d;

    logic               tick;
    logic               set_ok;
    logic [4:0]         hr_disp;

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = STOPPED;
        end else if (start_resume) begin
            state_d = RUNNING;
        end
    end

    assign tick   = (state_q == RUNNING) && (presc_q == DIV_M1);
    assign set_ok = (set_hr <= 5'(HR_MAX)) && (set_min <= 6'(MIN_MAX)) &&
                    (set_sec <= 6'(SEC_MAX));

    // A valid load wins over any coincident tick; a rejected load freezes
    // time and prescaler for that cycle.
    always_comb begin
        presc_d   = presc_q;
        hr_d      = hr_q;
        min_d     = min_q;
        sec_d     = sec_q;
        mode_d    = mode_q ^ mode_toggle;
        daypass_d = 1'b0;
        set_err_d = 1'b0;
        if (set_time && set_ok) begin
            hr_d    = set_hr;
            min_d   = set_min;
            sec_d   = set_sec;
            presc_d = '0;
        end else if (set_time) begin
            set_err_d = 1'b1;
        end else begin
            if (state_q == RUNNING) begin
                presc_d = tick ? '0 : presc_q + PRESC_W'(1);
            end
            if (tick) begin
                if (sec_q == 6'(SEC_MAX)) begin
                    sec_d = 6'd0;
                    if (min_q == 6'(MIN_MAX)) begin
                        min_d = 6'd0;
                        if (hr_q == 5'(HR_MAX)) begin
                            hr_d      = 5'd0;
                            daypass_d = 1'b1;
                        end else begin
                            hr_d = hr_q + 5'd1;
                        end
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= STOPPED;
            presc_q   <= '0;
            hr_q      <= 5'd0;
            min_q     <= 6'd0;
            sec_q     <= 6'd0;
            mode_q    <= RESET_24H;
            daypass_q <= 1'b0;
            set_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            hr_q      <= hr_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            mode_q    <= mode_d;
            daypass_q <= daypass_d;
            set_err_q <= set_err_d;
        end
    end

    // 12-hour view: 0 -> 12, 13..23 -> 1..11.
    always_comb begin
        hr_disp = hr_q;
        if (!mode_q) begin
            if (hr_q == 5'd0) begin
                hr_disp = 5'd12;
            end else if (hr_q > 5'd12) begin
                hr_disp = hr_q - 5'd12;
            end
        end
    end

    bin2bcd_2digit u_hr_bcd (
        .bin_i  ({1'b0, hr_disp}),
        .tens_o (hr1),
        .ones_o (hr0)
    );

    bin2bcd_2digit u_min_bcd (
        .bin_i  (min_q),
        .tens_o (min1),
        .ones_o (min0)
    );

    bin2bcd_2digit u_sec_bcd (
        .bin_i  (sec_q),
        .tens_o (sec1),
        .ones_o (sec0)
    );

    assign pm       = (hr_q >= 5'd12);
    assign mode_24h = mode_q;
    assign running  = (state_q == RUNNING);
    assign daypass  = daypass_q;
    assign set_err  = set_err_q;

endmodule

// File: doc/param_watch.md
PARAM_WATCH -- requirements
Module: param_watch

Interface
REQ-001 Parameter CLK_DIV, default 1: clk cycles per one-second tick; legal range 1..2^20.
REQ-002 Parameter RESET_24H, default 1: value loaded into the mode register at reset (1 = 24-hour, 0 = 12-hour display).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 start_resume  input  1  level; enter/stay RUNNING.
REQ-006 stop  input  1  level; enter/stay STOPPED.
REQ-007 set_time  input  1  one-cycle load strobe for set_hr/set_min/set_sec.
REQ-008 set_hr  input  5  binary hour, 0..23.
REQ-009 set_min  input  6  binary minute, 0..59.
REQ-010 set_sec  input  6  binary second, 0..59.
REQ-011 mode_toggle  input  1  one-cycle strobe; inverts 12/24-hour display mode.
REQ-012 hr1, hr0, min1, min0, sec1, sec0  output  4 each  BCD display digits.
REQ-013 pm  output  1  high when internal hour >= 12 (valid in both modes).
REQ-014 mode_24h  output  1  current display mode.
REQ-015 daypass  output  1  one-cycle pulse on 23:59:59 -> 00:00:00 rollover.
REQ-016 set_err  output  1  one-cycle pulse when a set_time load is rejected.
REQ-017 running  output  1  high in RUNNING state.

Function
REQ-018 Internal time SHALL be held in binary: hour 0..23, minute 0..59, second 0..59.
REQ-019 Two states: STOPPED, RUNNING; stop high -> STOPPED; else start_resume high -> RUNNING; neither -> hold; both high -> stop wins.
REQ-020 Prescaler SHALL count 0..CLK_DIV-1 only in RUNNING, holding its value in STOPPED; tick asserted in the cycle where count = CLK_DIV-1 and state is RUNNING; CLK_DIV = 1 gives a tick every running cycle.
REQ-021 On tick, seconds SHALL increment; 59 wraps to 0 and carries to minutes; minute 59 wraps to 0 and carries to hours; hour 23 wraps to 0 and asserts daypass for exactly one cycle, registered, coincident with the 00:00:00 update.
REQ-022 set_time with set_hr <= 23, set_min <= 59 and set_sec <= 59 SHALL load all three fields next edge, clear the prescaler, and suppress any coincident tick/carry/daypass.
REQ-023 set_time with any field out of range SHALL leave time and prescaler unchanged and pulse set_err one cycle.
REQ-024 set_time SHALL be honoured in both STOPPED and RUNNING and SHALL not change state.
REQ-025 mode_toggle SHALL invert mode next edge, independent of state, tick or set_time.
REQ-026 In 24-hour mode, hr1/hr0 SHALL show hour 00..23; in 12-hour mode, hr1/hr0 SHALL show 12 for hour 0 and 12, hour-12 for 13..23, and hour for 1..11.
REQ-027 Display outputs SHALL be combinational from registered state: zero-cycle latency after a time update.
REQ-028 BCD tens digits SHALL be confined to 0..5 (min/sec) and 0..2 (hour); unused digit codes never appear.

Reset
REQ-029 reset SHALL override all other inputs, including set_time.
REQ-030 After reset: time 00:00:00, state STOPPED, prescaler 0, mode = RESET_24H, daypass 0, set_err 0, running 0.
REQ-031 On reset, hr1/hr0 SHALL show 00 when RESET_24H = 1 and 12 when RESET_24H = 0; pm 0.

Structure
REQ-032 Package watch_pkg SHALL hold constants SEC_MAX = 59, MIN_MAX = 59, HR_MAX = 23 and the state enum (STOPPED, RUNNING).
REQ-033 One sub-module bin2bcd_2digit (6-bit binary 0..59 -> two BCD digits) SHALL be instantiated three times: hour, minute, second.

Verification
REQ-034 CLK_DIV=4, reset, start_resume 1 cycle -> seconds increment every 4 clks; stop after 10 clks -> time frozen at 00:00:02, prescaler held.
REQ-035 Set 23:59:58, run, CLK_DIV=1 -> 23:59:59 then 00:00:00 with daypass high exactly one cycle, pm 1 -> 0.
REQ-036 Set hr=24 min=0 sec=0 -> set_err one cycle, time unchanged; set 0:60:0 -> set_err one cycle, time unchanged.
REQ-037 Set 13:05:00, toggle to 12-hour -> hr1/hr0 = 0/1, pm 1; set 0:00:00 -> 1/2, pm 0; set 12:00:00 -> 1/2, pm 1.
REQ-038 start_resume and stop high together -> STOPPED; set_time coincident with tick at 00:00:59 loading 10:10:10 -> 10:10:10, no carry.
REQ-039 Reset asserted mid-run at 05:30:30 with set_time high -> 00:00:00, STOPPED, mode = RESET_24H, set ignored.
